// File: rtl/dpram_lanes.sv
// Byte-addressed true dual-port RAM, LANES cells per access, unaligned with modular wrap and per-cell write enables.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1), fully pipelined; writes take effect at the next edge.
// No backpressure: every read yields one valid pulse. Optional DPRAM_WR_FWD_EN: cross-port write-first forwarding.
module dpram_lanes #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16,
  parameter int DEPTH      = 519168,
  parameter int ADDR_WIDTH = 19,
  parameter int OUT_REG    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_a,
  input  logic                          we_a,
  input  logic [LANES-1:0]              be_a,
  input  logic [ADDR_WIDTH-1:0]         addr_a,
  input  logic [LANES*DATA_WIDTH-1:0]   din_a,
  output logic [LANES*DATA_WIDTH-1:0]   dout_a,
  output logic                          valid_a,
  input  logic                          en_b,
  input  logic                          we_b,
  input  logic [LANES-1:0]              be_b,
  input  logic [ADDR_WIDTH-1:0]         addr_b,
  input  logic [LANES*DATA_WIDTH-1:0]   din_b,
  output logic [LANES*DATA_WIDTH-1:0]   dout_b,
  output logic                          valid_b,
  output logic                          coll
);

  localparam int W  = LANES * DATA_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] pa_a [LANES];
  logic [ADDR_WIDTH-1:0] pa_b [LANES];

  logic [W-1:0] rd_dat_a_d, rd_dat_b_d;
  logic [W-1:0] rd_dat_a_q, rd_dat_b_q;
  logic         rd_vld_a_q, rd_vld_b_q;
  logic         coll_d, coll_q;

  logic wr_a, wr_b, rd_a, rd_b;

  assign wr_a = en_a & we_a;
  assign wr_b = en_b & we_b;
  assign rd_a = en_a & ~we_a;
  assign rd_b = en_b & ~we_b;

  // Physical cell of a lane: base reduced mod DEPTH, then one conditional
  // subtract covers the lane offset since base + lane < 2*DEPTH.
  function automatic logic [ADDR_WIDTH-1:0] phys(input logic [ADDR_WIDTH-1:0] addr, input int lane);
    logic [PW-1:0] sum;
    sum = PW'(32'(addr) % 32'(DEPTH)) + PW'(lane);
    if (sum >= PW'(DEPTH)) sum = sum - PW'(DEPTH);
    return sum[ADDR_WIDTH-1:0];
  endfunction

  // Per-lane physical addresses for both ports.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      pa_a[i] = phys(addr_a, i);
      pa_b[i] = phys(addr_b, i);
    end
  end

  // Read data gather, optional cross-port forwarding, and write/write overlap detect.
  always_comb begin
    rd_dat_a_d = '0;
    rd_dat_b_d = '0;
    coll_d     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      rd_dat_a_d[i*DATA_WIDTH +: DATA_WIDTH] = mem[IW'(pa_a[i])];
      rd_dat_b_d[i*DATA_WIDTH +: DATA_WIDTH] = mem[IW'(pa_b[i])];
    end
`ifdef DPRAM_WR_FWD_EN
    // A reading port can never also be writing, so only the other port's write is forwarded.
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (wr_b && be_b[j] && (pa_b[j] == pa_a[i]))
          rd_dat_a_d[i*DATA_WIDTH +: DATA_WIDTH] = din_b[j*DATA_WIDTH +: DATA_WIDTH];
        if (wr_a && be_a[j] && (pa_a[j] == pa_b[i]))
          rd_dat_b_d[i*DATA_WIDTH +: DATA_WIDTH] = din_a[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`endif
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (wr_a && wr_b && be_a[i] && be_b[j] && (pa_a[i] == pa_b[j]))
          coll_d = 1'b1;
      end
    end
  end

  // Storage update: A is applied before B so B's value lands last on shared cells.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_a) begin
        for (int i = 0; i < LANES; i++)
          if (be_a[i]) mem[IW'(pa_a[i])] <= din_a[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (wr_b) begin
        for (int i = 0; i < LANES; i++)
          if (be_b[i]) mem[IW'(pa_b[i])] <= din_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // First read stage and collision flag; data only loads on a read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat_a_q <= '0;
      rd_dat_b_q <= '0;
      rd_vld_a_q <= 1'b0;
      rd_vld_b_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      rd_vld_a_q <= rd_a;
      rd_vld_b_q <= rd_b;
      coll_q     <= coll_d;
      if (rd_a) rd_dat_a_q <= rd_dat_a_d;
      if (rd_b) rd_dat_b_q <= rd_dat_b_d;
    end
  end

  assign coll = coll_q;

  if (OUT_REG != 0) begin : g_oreg
    logic [W-1:0] out_dat_a_q, out_dat_b_q;
    logic         out_vld_a_q, out_vld_b_q;

    // Second read stage, loaded only when the first stage carries a result.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_dat_a_q <= '0;
        out_dat_b_q <= '0;
        out_vld_a_q <= 1'b0;
        out_vld_b_q <= 1'b0;
      end else begin
        out_vld_a_q <= rd_vld_a_q;
        out_vld_b_q <= rd_vld_b_q;
        if (rd_vld_a_q) out_dat_a_q <= rd_dat_a_q;
        if (rd_vld_b_q) out_dat_b_q <= rd_dat_b_q;
      end
    end

    assign dout_a  = out_dat_a_q;
    assign dout_b  = out_dat_b_q;
    assign valid_a = out_vld_a_q;
    assign valid_b = out_vld_b_q;
  end else begin : g_noreg
    assign dout_a  = rd_dat_a_q;
    assign dout_b  = rd_dat_b_q;
    assign valid_a = rd_vld_a_q;
    assign valid_b = rd_vld_b_q;
  end

endmodule

// File: tb/tb_dpram_lanes.sv
// Drives two dpram_lanes instances (OUT_REG=0 and OUT_REG=1) with identical stimulus.
// A cell-level reference memory predicts read data, latency, collisions and reset effects.
// Expected reads are queued at issue; a negedge monitor pops and compares as outputs appear.
module tb_dpram_lanes;
  localparam int DW  = 8;
  localparam int L   = 16;
  localparam int DEP = 64;
  localparam int AW  = 7;
  localparam int W   = L * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en_a, we_a, en_b, we_b;
  logic [L-1:0]  be_a, be_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [W-1:0]  din_a, din_b;

  // Stream index: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
  logic [W-1:0] dout_s [4];
  logic [3:0]   valid_s;
  logic [1:0]   coll_s;

  dpram_lanes #(.DATA_WIDTH(DW), .LANES(L), .DEPTH(DEP), .ADDR_WIDTH(AW), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_s[0]), .valid_a(valid_s[0]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_s[1]), .valid_b(valid_s[1]),
    .coll(coll_s[0])
  );

  dpram_lanes #(.DATA_WIDTH(DW), .LANES(L), .DEPTH(DEP), .ADDR_WIDTH(AW), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_s[2]), .valid_a(valid_s[2]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_s[3]), .valid_b(valid_s[3]),
    .coll(coll_s[1])
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] d;
  } exp_t;

  exp_t         sb [4][$];
  logic [7:0]   mem_m [DEP];
  logic [W-1:0] last [4];
  int           cyc = 0;
  bit           rst_q = 1'b0;
  bit           mon_en = 1'b0;
  bit           exp_coll_next = 1'b0;
  bit           exp_coll_cur = 1'b0;
  int           checks = 0;
  int           errors = 0;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    rst_q        <= rst;
    exp_coll_cur <= exp_coll_next;
  end

  // One cycle of stimulus plus the reference-model update for it.
  task automatic drive(input bit r,
                       input bit ea, input bit wa, input logic [L-1:0] ba,
                       input logic [AW-1:0] aa, input logic [W-1:0] da,
                       input bit eb, input bit wb, input logic [L-1:0] bb,
                       input logic [AW-1:0] ab, input logic [W-1:0] db);
    bit           hit_a [DEP];
    bit           hit_b [DEP];
    logic [7:0]   val_a [DEP];
    logic [7:0]   val_b [DEP];
    logic [W-1:0] ra, rb;
    exp_t         keep [$];
    int           c;
    @(posedge clk);
    #1;
    rst = r; en_a = ea; we_a = wa; be_a = ba; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; be_b = bb; addr_b = ab; din_b = db;
    for (int k = 0; k < DEP; k++) begin
      hit_a[k] = 1'b0; hit_b[k] = 1'b0; val_a[k] = '0; val_b[k] = '0;
    end
    exp_coll_next = 1'b0;
    ra = '0;
    rb = '0;
    if (r) begin
      // Anything due after this reset edge is dropped.
      for (int p = 0; p < 4; p++) begin
        keep = {};
        foreach (sb[p][k]) if (sb[p][k].cyc <= cyc) keep.push_back(sb[p][k]);
        sb[p] = keep;
      end
    end else begin
      if (ea && wa) for (int i = 0; i < L; i++) if (ba[i]) begin
        c = (int'(aa) + i) % DEP; hit_a[c] = 1'b1; val_a[c] = da[i*8 +: 8];
      end
      if (eb && wb) for (int i = 0; i < L; i++) if (bb[i]) begin
        c = (int'(ab) + i) % DEP; hit_b[c] = 1'b1; val_b[c] = db[i*8 +: 8];
      end
      for (int k = 0; k < DEP; k++) if (hit_a[k] && hit_b[k]) exp_coll_next = 1'b1;
      if (ea && !wa) begin
        for (int i = 0; i < L; i++) begin
          c = (int'(aa) + i) % DEP;
          ra[i*8 +: 8] = mem_m[c];
`ifdef DPRAM_WR_FWD_EN
          if (hit_b[c]) ra[i*8 +: 8] = val_b[c];
`endif
        end
        sb[0].push_back('{cyc + 1, ra});
        sb[2].push_back('{cyc + 2, ra});
      end
      if (eb && !wb) begin
        for (int i = 0; i < L; i++) begin
          c = (int'(ab) + i) % DEP;
          rb[i*8 +: 8] = mem_m[c];
`ifdef DPRAM_WR_FWD_EN
          if (hit_a[c]) rb[i*8 +: 8] = val_a[c];
`endif
        end
        sb[1].push_back('{cyc + 1, rb});
        sb[3].push_back('{cyc + 2, rb});
      end
      for (int k = 0; k < DEP; k++) begin
        if (hit_a[k]) mem_m[k] = val_a[k];
        if (hit_b[k]) mem_m[k] = val_b[k];
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic rd_a(input logic [AW-1:0] a);
    drive(0, 1, 0, '0, a, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic rd_b(input logic [AW-1:0] a);
    drive(0, 0, 0, '0, '0, '0, 1, 0, '0, a, '0);
  endtask

  // Monitor: valid must match the queue head exactly on its due cycle; dout holds otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) for (int p = 0; p < 4; p++) last[p] = '0;
      for (int p = 0; p < 4; p++) begin
        bit ev;
        ev = (sb[p].size() > 0) && (sb[p][0].cyc == cyc);
        checks++;
        if (valid_s[p] !== ev) begin
          errors++;
          $display("FAIL valid stream%0d cyc %0d: got %b want %b", p, cyc, valid_s[p], ev);
        end
        if (ev) begin
          last[p] = sb[p][0].d;
          void'(sb[p].pop_front());
        end
        checks++;
        if (dout_s[p] !== last[p]) begin
          errors++;
          $display("FAIL dout stream%0d cyc %0d: got %h want %h", p, cyc, dout_s[p], last[p]);
        end
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (coll_s[d] !== exp_coll_cur) begin
          errors++;
          $display("FAIL coll dut%0d cyc %0d: got %b want %b", d, cyc, coll_s[d], exp_coll_cur);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    bit           r, ea, wa, eb, wb;
    logic [L-1:0] ba, bb;
    logic [AW-1:0] aa, ab;
    logic [W-1:0] da, db;

    rst = 1'b1; en_a = 1'b0; we_a = 1'b0; be_a = '0; addr_a = '0; din_a = '0;
    en_b = 1'b0; we_b = 1'b0; be_b = '0; addr_b = '0; din_b = '0;
    for (int p = 0; p < 4; p++) last[p] = '0;
    repeat (3) drive(1, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    mon_en = 1'b1;

    // Fill every cell so all later reads are defined.
    for (int k = 0; k < 4; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      drive(0, 1, 1, '1, AW'(k * 16), d, 0, 0, '0, '0, '0);
    end

    // Aligned write then read on the next cycle.
    for (int i = 0; i < L; i++) d[i*8 +: 8] = 8'(i);
    drive(0, 1, 1, '1, 7'd0, d, 0, 0, '0, '0, '0);
    rd_a(7'd0);

    // Unaligned partial write from B.
    drive(0, 0, 0, '0, '0, '0, 1, 1, 16'h00FF, 7'd5, '1);
    rd_a(7'd0);
    rd_b(7'd16);

    // Wrap across the end of the array, plus an address beyond DEPTH.
    for (int i = 0; i < L; i++) d[i*8 +: 8] = 8'(16 + i);
    drive(0, 1, 1, '1, 7'd56, d, 0, 0, '0, '0, '0);
    rd_a(7'd56);
    rd_b(7'd0);
    rd_a(7'd120);

    // Write/write collision: B wins on the overlap.
    drive(0, 1, 1, '1, 7'd8, {16{8'hAA}}, 1, 1, '1, 7'd0, {16{8'hBB}});
    drive(0, 1, 0, '0, 7'd0, '0, 1, 0, '0, 7'd16, '0);
    // Same cells but disjoint byte enables: no collision.
    drive(0, 1, 1, 16'h00FF, 7'd8, {16{8'h33}}, 1, 1, 16'hFF00, 7'd8, {16{8'h44}});
    rd_a(7'd8);

    // Cross-port read of a cell being written in the same cycle.
    drive(0, 1, 1, 16'h0001, 7'd4, {{15{8'h00}}, 8'h11}, 0, 0, '0, '0, '0);
    drive(0, 1, 0, '0, 7'd0, '0, 1, 1, 16'h0001, 7'd4, {{15{8'h00}}, 8'h22});
    drive(0, 1, 1, 16'h0003, 7'd40, {16{8'h5C}}, 1, 0, '0, 7'd32, '0);
    rd_a(7'd0);

    // Reset while reads are in flight; memory must survive.
    rd_a(7'd0);
    drive(1, 1, 0, '0, 7'd16, '0, 1, 1, '1, 7'd0, {16{8'hEE}});
    idle(3);
    rd_a(7'd0);
    rd_b(7'd8);
    idle(3);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 59) == 0);
      ea = ($urandom_range(0, 3) != 0);
      wa = 1'($urandom);
      ba = 16'($urandom);
      aa = 7'($urandom_range(0, 127));
      da = {$urandom, $urandom, $urandom, $urandom};
      eb = ($urandom_range(0, 3) != 0);
      wb = 1'($urandom);
      bb = 16'($urandom);
      ab = 7'($urandom_range(0, 127));
      db = {$urandom, $urandom, $urandom, $urandom};
      drive(r, ea, wa, ba, aa, da, eb, wb, bb, ab, db);
    end

    idle(5);
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (sb[p].size() != 0) begin
        errors++;
        $display("FAIL drain stream%0d: %0d reads never appeared, want 0", p, sb[p].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
